sliding_ones_counter: RTL
=========================

# sliding_ones_counter

Parametrised sliding-window ones counter for serial bit streams. Counts the '1' bits among the last WINDOW accepted samples, with a valid qualifier, a synchronous flush, and window-fill tracking. An optional hysteresis density alarm is included. Used in the serial-monitor path wherever link or bit-error density is tracked over a bounded history.

## Interface
- WINDOW, 10, number of most recent accepted bits counted; legal range 1..1024
- THRESH_HI, 7, alarm asserts when count >= THRESH_HI; requires THRESH_LO < THRESH_HI <= WINDOW
- THRESH_LO, 3, alarm deasserts when count <= THRESH_LO
- CW (localparam), $clog2(WINDOW+1), count width; WINDOW=10 gives 4

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- data_valid  in  1  sample data_in on this edge
- data_in  in  1  serial bit
- clear  in  1  synchronous flush of window, count and fill state
- ones_count  out  CW  number of '1's in the window, registered
- fill_level  out  CW  number of bits currently held, saturates at WINDOW
- window_full  out  1  high when fill_level == WINDOW
- alarm  out  1  hysteresis density flag

## Operation
- Window storage: WINDOW-bit shift register. On an accepted bit, data_in enters position 0 and the oldest bit leaves position WINDOW-1.
- Count update on an accepted bit: next = ones_count + data_in - oldest. While window_full=0, oldest is treated as 0.
- Count arithmetic is exact in CW bits. Never negative, never above WINDOW. No saturation logic is needed and none is allowed.
- data_valid=0: all state holds.
- fill_level increments per accepted bit until it reaches WINDOW, then holds.
- clear=1: shift register, ones_count, fill_level and alarm go to 0 on that edge. clear overrides a simultaneous data_valid, and that bit is discarded.
- reset behaves exactly like clear and has priority over everything.
- Reset values: ones_count=0, fill_level=0, window_full=0, alarm=0.
- Alarm is a two-state FSM (IDLE, ALARM), evaluated on the next-count value at the same edge:
  - IDLE -> ALARM when next >= THRESH_HI.
  - ALARM -> IDLE when next <= THRESH_LO.
  - Otherwise the state holds.
- WINDOW=1: ones_count equals the last accepted bit; window_full=1 after the first accepted bit.

## Timing
- Latency: a bit sampled at edge k is reflected in ones_count, fill_level, window_full and alarm immediately after edge k (1 cycle, registered).
- Throughput: one bit per clock. data_valid may stay high indefinitely.
- At wrap-around (window_full=1), add and remove happen in the same edge. ones_count changes by -1, 0 or +1 per accepted bit.
- All outputs are glitch-free registers. No combinational input-to-output path.

## Configuration
- SLIDING_ONES_ALARM_EN defined: the hysteresis FSM, THRESH_HI and THRESH_LO are active as described.
- SLIDING_ONES_ALARM_EN undefined: the FSM is not built, alarm is tied to 0, and the threshold parameters are ignored. Counting behaviour is identical.

## Test plan
- Reset, then WINDOW=10 with valid bits 1,0,1,0,0,1,1,0,0,1 -> ones_count steps 1,1,2,2,2,3,4,4,4,5; window_full=1 after the 10th bit; fill_level=10.
- Continue with bits 1,1 -> oldest bits 1,0 leave, so ones_count goes 5 then 6. Then 10 zeros -> count decrements to 0, and window_full stays 1.
- Drive data_valid=0 for 5 cycles mid-stream -> ones_count and fill_level hold. Next valid '1' -> count +1 minus the evicted bit.
- clear with data_valid=1 and data_in=1 on the same edge -> ones_count=0, fill_level=0, alarm=0, bit discarded. Next valid '1' -> count=1, fill_level=1.
- With SLIDING_ONES_ALARM_EN, HI=7, LO=3: eight consecutive 1s -> alarm rises on the edge where the count reaches 7. Then zeros -> alarm falls only on the edge where the count reaches 3. Without the macro -> alarm stays 0 throughout.
- Assert reset mid-stream with count=6 -> all outputs 0 on that edge. WINDOW=1 build: bits 1,0,1 -> count 1,0,1, window_full=1 from the first bit.

Source files
------------

// File: rtl/sliding_ones_counter_if.sv
// Bus bundle for sliding_ones_counter: sample stream and flush in, registered count/fill/alarm out.
// Handshake: a bit is accepted on every rising edge where data_valid=1; there is no ready, the counter always accepts.
interface sliding_ones_counter_if #(
    parameter int WINDOW = 10
) ();
    localparam int CW = $clog2(WINDOW + 1);

    logic          data_valid;
    logic          data_in;
    logic          clear;
    logic [CW-1:0] ones_count;
    logic [CW-1:0] fill_level;
    logic          window_full;
    logic          alarm;
    logic          alarm_state;

    modport master (
        output data_valid, data_in, clear,
        input  ones_count, fill_level, window_full, alarm, alarm_state
    );

    modport slave (
        input  data_valid, data_in, clear,
        output ones_count, fill_level, window_full, alarm, alarm_state
    );
endinterface

// File: rtl/sliding_ones_counter.sv
// Counts '1' bits among the last WINDOW accepted samples, with fill tracking and flush.
// Define SLIDING_ONES_ALARM_EN to build the IDLE/ALARM hysteresis density flag.
module sliding_ones_counter #(
    parameter int WINDOW    = 10,
    parameter int THRESH_HI = 7,
    parameter int THRESH_LO = 3
) (
    input logic                  clk,
    input logic                  reset,
    sliding_ones_counter_if.slave bus
);
    localparam int CW = $clog2(WINDOW + 1);

    if (WINDOW < 1 || WINDOW > 1024 || THRESH_LO >= THRESH_HI || THRESH_HI > WINDOW) begin : g_bad_params
        $error("sliding_ones_counter: illegal WINDOW/THRESH_HI/THRESH_LO combination");
    end

    logic [WINDOW-1:0] window_q;
    logic [WINDOW-1:0] window_next;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_next;
    logic [CW-1:0]     fill_q;
    logic              full_q;
    logic              oldest;
    logic              flush;

    if (WINDOW == 1) begin : g_w1
        assign window_next = bus.data_in;
    end else begin : g_wn
        assign window_next = {window_q[WINDOW-2:0], bus.data_in};
    end

    // Until the window has filled, the bit at the top of the register is stale reset padding.
    assign oldest     = full_q & window_q[WINDOW-1];
    assign count_next = count_q + CW'(bus.data_in) - CW'(oldest);
    assign flush      = reset | bus.clear;

    always_ff @(posedge clk) begin
        if (flush) begin
            window_q <= '0;
            count_q  <= '0;
            fill_q   <= '0;
            full_q   <= 1'b0;
        end else if (bus.data_valid) begin
            window_q <= window_next;
            count_q  <= count_next;
            if (!full_q) begin
                fill_q <= fill_q + CW'(1);
            end
            full_q <= full_q | (fill_q == CW'(WINDOW - 1));
        end
    end

    assign bus.ones_count  = count_q;
    assign bus.fill_level  = fill_q;
    assign bus.window_full = full_q;

`ifdef SLIDING_ONES_ALARM_EN
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ALARM = 1'b1
    } alarm_state_t;

    alarm_state_t state_q;
    alarm_state_t state_d;

    always_ff @(posedge clk) begin
        if (flush) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Thresholds are judged against the count that will be registered on this edge.
    always_comb begin
        state_d = state_q;
        if (bus.data_valid) begin
            case (state_q)
                S_IDLE:  if (count_next >= CW'(THRESH_HI)) state_d = S_ALARM;
                S_ALARM: if (count_next <= CW'(THRESH_LO)) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.alarm       = (state_q == S_ALARM);
    assign bus.alarm_state = state_q;
`else
    assign bus.alarm       = 1'b0;
    assign bus.alarm_state = 1'b0;
`endif

endmodule
